// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, control-word layout and microcode decode
//
// Purpose : Opcode constants, the default final micro-step index and the bit
//           positions of the internal control word used by control_sequencer.
//           ctrl_decode() maps (step, opcode, flags) to a control word.
// Ports   : none (package)
package ctrl_pkg;

  localparam int LAST_STEP_DEFAULT = 4;
  localparam int STEP_W            = 3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit positions. CW_HLT is internal only: it never reaches a
  // port, but it makes the HLT execute step count as an occupied step.
  localparam int CW_PC_OUT   = 0;
  localparam int CW_RAM_OUT  = 1;
  localparam int CW_IR_OUT   = 2;
  localparam int CW_A_OUT    = 3;
  localparam int CW_ALU_OUT  = 4;
  localparam int CW_MAR_IN   = 5;
  localparam int CW_RAM_IN   = 6;
  localparam int CW_IR_IN    = 7;
  localparam int CW_A_IN     = 8;
  localparam int CW_B_IN     = 9;
  localparam int CW_OUT_IN   = 10;
  localparam int CW_PC_IN    = 11;
  localparam int CW_FLAGS_IN = 12;
  localparam int CW_PC_INC   = 13;
  localparam int CW_ALU_SUB  = 14;
  localparam int CW_HLT      = 15;
  localparam int CW_WIDTH    = 16;

  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

  // step is one bit wider than the counter so the caller can ask about the
  // step after the current one without overflow.
  function automatic ctrl_word_t ctrl_decode(input logic [3:0] step,
                                             input logic [3:0] op,
                                             input logic       carry,
                                             input logic       zero);
    ctrl_word_t cw;
    cw = '0;
    case (step)
      4'd0: begin
        cw[CW_PC_OUT] = 1'b1;
        cw[CW_MAR_IN] = 1'b1;
      end
      4'd1: begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_IN]   = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      4'd2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_A_IN]   = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_PC_IN]  = 1'b1;
          end
          // The only place the flags are looked at.
          OP_JC: begin
            cw[CW_IR_OUT] = carry;
            cw[CW_PC_IN]  = carry;
          end
          OP_JZ: begin
            cw[CW_IR_OUT] = zero;
            cw[CW_PC_IN]  = zero;
          end
          OP_OUT: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_OUT_IN] = 1'b1;
          end
          OP_HLT:  cw[CW_HLT] = 1'b1;
          OP_NOP:  cw = '0;
          default: cw = '0;
        endcase
      end
      4'd3: begin
        case (op)
          OP_LDA: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_A_IN]    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_IN]    = 1'b1;
          end
          OP_STA: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_RAM_IN] = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      4'd4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          cw[CW_ALU_OUT]  = 1'b1;
          cw[CW_A_IN]     = 1'b1;
          cw[CW_FLAGS_IN] = 1'b1;
          cw[CW_ALU_SUB]  = (op == OP_SUB);
        end
      end
      default: cw = '0;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - micro-step counter with enable, sync clear and wrap
//
// Purpose : Counts 0..LAST, wrapping to 0 after LAST. i_clr has priority over
//           i_en and returns the count to 0 on the next clock.
// Ports   : clk     - clock, rising edge
//           rst_n   - asynchronous active-low reset
//           i_en    - advance by one per clock when high
//           i_clr   - synchronous clear to 0
//           o_count - current count
module step_counter #(
  parameter int WIDTH = 3,
  parameter int LAST  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(LAST);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      // >= rather than == so an out-of-range value can never persist.
      if (r_count >= LAST_VAL) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - micro-step control sequencer for an 8-bit CPU
//
// Purpose : Steps through fetch (0,1) and execute (2..4) micro-steps and
//           decodes the bus-driver / load / misc controls from step, opcode
//           and flags. Steps with no active controls are skipped by looking
//           one step ahead; HLT latches a halted state until reset.
// Ports   : clk, reset (async active-low), run (advance enable)
//           opcode[3:0], carry_flag, zero_flag        - decode inputs
//           *_data_out                                - bus drivers
//           *_data_in, flags_in                       - register loads
//           pc_inc, alu_sub, halt, step[2:0]          - misc / status
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int LAST_STEP = LAST_STEP_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       pc_data_out,
  output logic       ram_data_out,
  output logic       ir_data_out,
  output logic       a_data_out,
  output logic       alu_data_out,
  output logic       mar_data_in,
  output logic       ram_data_in,
  output logic       ir_data_in,
  output logic       a_data_in,
  output logic       b_data_in,
  output logic       out_data_in,
  output logic       pc_data_in,
  output logic       flags_in,
  output logic       pc_inc,
  output logic       alu_sub,
  output logic       halt,
  output logic [2:0] step
);

  logic              r_halted;
  logic              w_active;
  logic              w_next_idle;
  logic [STEP_W-1:0] w_step;
  ctrl_word_t        w_cw;
  ctrl_word_t        w_cw_next;
  ctrl_word_t        w_cw_out;

  assign w_active = run & ~r_halted;

  assign w_cw      = ctrl_decode({1'b0, w_step}, opcode, carry_flag, zero_flag);
  // When the following step would do nothing, this step ends the instruction.
  assign w_cw_next = ctrl_decode({1'b0, w_step} + 4'd1, opcode, carry_flag, zero_flag);
  assign w_next_idle = (w_cw_next == '0);

  step_counter #(
    .WIDTH (STEP_W),
    .LAST  (LAST_STEP)
  ) u_step_counter (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_active),
    .i_clr   (w_active & w_next_idle),
    .o_count (w_step)
  );

  // reset is also used combinationally so outputs drop without a clock edge.
  assign w_cw_out = (reset && w_active) ? w_cw : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halted <= 1'b0;
    end else if (w_cw_out[CW_HLT]) begin
      r_halted <= 1'b1;
    end
  end

  assign pc_data_out  = w_cw_out[CW_PC_OUT];
  assign ram_data_out = w_cw_out[CW_RAM_OUT];
  assign ir_data_out  = w_cw_out[CW_IR_OUT];
  assign a_data_out   = w_cw_out[CW_A_OUT];
  assign alu_data_out = w_cw_out[CW_ALU_OUT];
  assign mar_data_in  = w_cw_out[CW_MAR_IN];
  assign ram_data_in  = w_cw_out[CW_RAM_IN];
  assign ir_data_in   = w_cw_out[CW_IR_IN];
  assign a_data_in    = w_cw_out[CW_A_IN];
  assign b_data_in    = w_cw_out[CW_B_IN];
  assign out_data_in  = w_cw_out[CW_OUT_IN];
  assign pc_data_in   = w_cw_out[CW_PC_IN];
  assign flags_in     = w_cw_out[CW_FLAGS_IN];
  assign pc_inc       = w_cw_out[CW_PC_INC];
  assign alu_sub      = w_cw_out[CW_ALU_SUB];
  assign halt         = r_halted;
  assign step         = w_step;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, carry_flag, zero_flag;
  logic [3:0] opcode;
  logic       pc_data_out, ram_data_out, ir_data_out, a_data_out, alu_data_out;
  logic       mar_data_in, ram_data_in, ir_data_in, a_data_in, b_data_in;
  logic       out_data_in, pc_data_in, flags_in, pc_inc, alu_sub, halt;
  logic [2:0] step;

  always #5 clk = ~clk;

  control_sequencer #(.LAST_STEP(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_data_out(pc_data_out), .ram_data_out(ram_data_out),
    .ir_data_out(ir_data_out), .a_data_out(a_data_out),
    .alu_data_out(alu_data_out), .mar_data_in(mar_data_in),
    .ram_data_in(ram_data_in), .ir_data_in(ir_data_in),
    .a_data_in(a_data_in), .b_data_in(b_data_in),
    .out_data_in(out_data_in), .pc_data_in(pc_data_in),
    .flags_in(flags_in), .pc_inc(pc_inc), .alu_sub(alu_sub),
    .halt(halt), .step(step)
  );

  // Bench's own naming of the controls (bit 15 marks the HLT step).
  localparam int PC_OUT = 0,  RAM_OUT = 1, IR_OUT = 2,  A_OUT = 3,  ALU_OUT = 4;
  localparam int MAR_IN = 5,  RAM_IN = 6,  IR_IN = 7,   A_IN = 8,   B_IN = 9;
  localparam int OUT_IN = 10, PC_IN = 11,  FLAGS_IN = 12, PC_INC = 13, ALU_SUB = 14;
  localparam int HLT_MARK = 15;

  typedef struct packed {
    logic [2:0]  step;
    logic [14:0] ctl;
    logic        halt;
  } obs_t;

  obs_t        exp_q[$];
  logic [15:0] mprog[$];
  int          idx;
  bit          halted;
  int          checks;
  int          failures;
  string       phase;
  logic [14:0] act_ctl;

  assign act_ctl = {alu_sub, pc_inc, flags_in, pc_data_in, out_data_in, b_data_in,
                    a_data_in, ir_data_in, ram_data_in, mar_data_in, alu_data_out,
                    a_data_out, ir_data_out, ram_data_out, pc_data_out};

  function automatic logic [15:0] sig(input int i);
    return 16'd1 << i;
  endfunction

  // Whole-instruction microprogram: list of control sets, one per cycle.
  task automatic build_prog(input logic [3:0] op, input logic cf, input logic zf);
    logic [15:0] ld_addr;
    ld_addr = sig(IR_OUT) | sig(MAR_IN);
    mprog.delete();
    mprog.push_back(sig(PC_OUT) | sig(MAR_IN));
    mprog.push_back(sig(RAM_OUT) | sig(IR_IN) | sig(PC_INC));
    case (op)
      4'h1: begin
        mprog.push_back(ld_addr);
        mprog.push_back(sig(RAM_OUT) | sig(A_IN));
      end
      4'h2, 4'h3: begin
        mprog.push_back(ld_addr);
        mprog.push_back(sig(RAM_OUT) | sig(B_IN));
        mprog.push_back(sig(ALU_OUT) | sig(A_IN) | sig(FLAGS_IN) |
                        ((op == 4'h3) ? sig(ALU_SUB) : 16'h0));
      end
      4'h4: begin
        mprog.push_back(ld_addr);
        mprog.push_back(sig(A_OUT) | sig(RAM_IN));
      end
      4'h5: mprog.push_back(sig(IR_OUT) | sig(A_IN));
      4'h6: mprog.push_back(sig(IR_OUT) | sig(PC_IN));
      4'h7: if (cf) mprog.push_back(sig(IR_OUT) | sig(PC_IN));
      4'h8: if (zf) mprog.push_back(sig(IR_OUT) | sig(PC_IN));
      4'hE: mprog.push_back(sig(A_OUT) | sig(OUT_IN));
      4'hF: mprog.push_back(sig(HLT_MARK));
      default: ;
    endcase
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, advance
  // the model and wait for the next cycle.
  task automatic drive_cycle();
    obs_t        e;
    logic [15:0] w;
    bit          go_halt;
    e = '0;
    go_halt = 0;
    if (!reset) begin
      idx = 0;
      halted = 0;
    end else if (halted) begin
      e.halt = 1'b1;
    end else begin
      if (idx == 0) build_prog(opcode, carry_flag, zero_flag);
      e.step = 3'(idx);
      if (run) begin
        w = mprog[idx];
        e.ctl = w[14:0];
        go_halt = w[HLT_MARK];
        idx = (idx + 1) % mprog.size();
      end
    end
    exp_q.push_back(e);
    if (go_halt) halted = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic cf, input logic zf);
    int guard;
    opcode = op;
    carry_flag = cf;
    zero_flag = zf;
    run = 1'b1;
    drive_cycle();
    guard = 0;
    while (idx != 0 && guard < 10) begin
      drive_cycle();
      guard++;
    end
  endtask

  always @(negedge clk) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (step !== e.step) begin
        failures++;
        $display("FAIL step [%s] got=%0d exp=%0d", phase, step, e.step);
      end
      checks++;
      if (act_ctl !== e.ctl) begin
        failures++;
        $display("FAIL ctl [%s] step=%0d got=%015b exp=%015b", phase, step, act_ctl, e.ctl);
      end
      checks++;
      if (halt !== e.halt) begin
        failures++;
        $display("FAIL halt [%s] got=%b exp=%b", phase, halt, e.halt);
      end
      checks++;
      if ($countones(act_ctl[4:0]) > 1) begin
        failures++;
        $display("FAIL bus_onehot [%s] got=%05b exp=at most one set", phase, act_ctl[4:0]);
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    idx = 0;
    halted = 0;
    reset = 1'b0;
    run = 1'b0;
    opcode = 4'h0;
    carry_flag = 1'b0;
    zero_flag = 1'b0;
    phase = "reset";
    @(posedge clk);
    #1;
    run = 1'b1;
    drive_cycle();
    drive_cycle();
    reset = 1'b1;

    phase = "lda";    run_instr(4'h1, 1'b0, 1'b0);
    phase = "add";    run_instr(4'h2, 1'b1, 1'b0);
    phase = "sub";    run_instr(4'h3, 1'b0, 1'b1);
    phase = "jz_t";   run_instr(4'h8, 1'b0, 1'b1);
    phase = "jz_n";   run_instr(4'h8, 1'b1, 1'b0);
    phase = "jc_t";   run_instr(4'h7, 1'b1, 1'b0);
    phase = "jc_n";   run_instr(4'h7, 1'b0, 1'b1);
    phase = "jmp";    run_instr(4'h6, 1'b0, 1'b0);
    phase = "ldi";    run_instr(4'h5, 1'b0, 1'b0);
    phase = "out";    run_instr(4'hE, 1'b0, 1'b0);
    phase = "nop_b";  run_instr(4'hB, 1'b0, 1'b0);
    phase = "nop_0";  run_instr(4'h0, 1'b0, 1'b0);

    phase = "pause_sta";
    opcode = 4'h4;
    run = 1'b1;
    for (int g = 0; g < 10 && idx != 2; g++) drive_cycle();
    run = 1'b0;
    repeat (3) drive_cycle();
    run = 1'b1;
    for (int g = 0; g < 10 && idx != 0; g++) drive_cycle();

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      if (idx == 0) begin
        opcode = 4'($urandom_range(0, 14));
        carry_flag = 1'($urandom_range(0, 1));
        zero_flag = 1'($urandom_range(0, 1));
      end else if (opcode != 4'h7 && opcode != 4'h8) begin
        carry_flag = 1'($urandom_range(0, 1));
        zero_flag = 1'($urandom_range(0, 1));
      end
      run = ($urandom_range(0, 3) != 0);
      drive_cycle();
    end
    run = 1'b1;
    for (int g = 0; g < 10 && idx != 0; g++) drive_cycle();

    phase = "reset_mid_add";
    opcode = 4'h2;
    for (int g = 0; g < 10 && idx != 3; g++) drive_cycle();
    reset = 1'b0;
    drive_cycle();
    drive_cycle();
    reset = 1'b1;
    phase = "after_reset";
    run_instr(4'h1, 1'b0, 1'b0);

    phase = "halt";
    run_instr(4'hF, 1'b0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      run = 1'($urandom_range(0, 1));
      opcode = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag = 1'($urandom_range(0, 1));
      drive_cycle();
    end
    reset = 1'b0;
    drive_cycle();
    reset = 1'b1;
    phase = "post_halt";
    run_instr(4'h5, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
